fib_seq_engine: RTL
===================

# fib_seq_engine

Parametrised iterative Fibonacci/Lucas sequence engine with start/ready/done handshake and saturation at a configurable ceiling. It generalises the fixed 14-bit, index-20 Fibonacci operator. Result width, index width and saturation limit are parameters, and a Lucas mode is added. It sits between the switch/button input front end and a binary-to-BCD or display stage; `MAX_VAL` keeps results inside that stage's range.

## Interface
- `W`, default 16: result width in bits.
- `IDX_W`, default 6: index width, n = 0 .. 2^IDX_W−1.
- `MAX_VAL`, default 9999: saturation ceiling. Elaboration error unless 2 ≤ `MAX_VAL` ≤ 2^W−1.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, synchronous and active-high.
- `i_start`  in  1  start request; sampled only while `o_ready`=1.
- `i_mode`  in  1  0 = Fibonacci (seeds 0, 1); 1 = Lucas (seeds 2, 1). Latched at start.
- `i_idx`  in  IDX_W  sequence index n. Latched at start.
- `o_ready`  out  1  high in IDLE only.
- `o_done_tick`  out  1  one-cycle pulse in DONE.
- `o_final`  out  W  registered result; held until the next completion.
- `o_overflow`  out  1  registered; 1 means the result was clipped to `MAX_VAL`. Held until the next accepted start.

## Operation
- States: IDLE, OPERATE, DONE. Reset or an illegal encoding goes to IDLE.
- Internal registers:
  - `a`, `b`: W bits.
  - `n`: IDX_W bits.
  - result: W bits.
  - overflow flag: 1 bit.
- IDLE, when `i_start`=1:
  - `a` ← seed0, `b` ← seed1, `n` ← `i_idx`.
  - Overflow flag ← 0.
  - Go to OPERATE.
- OPERATE, in priority order:
  - n==0: result ← `a`; go to DONE.
  - n==1: result ← `b`; go to DONE.
  - Otherwise, compute sum = `a`+`b` in W+1 bits; the sum never wraps.
    - If sum > `MAX_VAL`: result ← `MAX_VAL`, overflow ← 1, go to DONE.
    - Else: `a` ← `b`, `b` ← sum[W−1:0], `n` ← n−1.
- DONE: `o_done_tick`=1; go to IDLE unconditionally.
- A sum is computed only when its term is actually required (index ≤ n), so overflow is never flagged for an in-range result.
- `i_start` while not in IDLE (OPERATE or DONE) is ignored and not queued.
- `i_mode` and `i_idx` changes after the start cycle have no effect.
- Reset mid-operation:
  - Abort the operation; go to IDLE.
  - Clear `a`, `b`, `n`, result and overflow.
  - No done tick.

## Timing
- Reset values:
  - `o_ready`=1 (IDLE).
  - `o_done_tick`=0.
  - `o_final`=0.
  - `o_overflow`=0.
- Let cycle 0 be the edge where start is accepted. OPERATE occupies cycles 1..k and DONE is cycle k+1.
  - n=0 or n=1: k=1, so `o_done_tick` at cycle 2.
  - n≥2, no overflow: k=n, so done tick at cycle n+1.
  - Overflow: k is the cycle whose sum exceeds `MAX_VAL`, at most n−1; done tick at k+1.
- `o_final` and `o_overflow` are valid from the done-tick cycle and stable until the next completion or accepted start.
- `o_ready` falls the cycle after start and returns the cycle after the done tick.
- Back-to-back operation: start asserted in the first cycle of IDLE is accepted.

## Structure
- Package `fib_pkg`:
  - `t_fib_state` enum (IDLE, OPERATE, DONE).
  - `t_fib_mode` enum (FIB=0, LUCAS=1).
  - Seed constants: FIB 0/1, LUCAS 2/1.
- Sub-module `fib_sat_add`: combinational, parameters `W` and `MAX_VAL`. Inputs a, b; outputs sum[W−1:0] and `sat` (sum > `MAX_VAL`).
- Top: FSMD with state/data register block plus a next-state/output block.

## Test plan
- Default params, mode 0, n=20 → `o_final`=6765, `o_overflow`=0, done tick exactly at cycle 21.
- Default params, mode 0, n=21 → `o_final`=9999, `o_overflow`=1, done tick at cycle 21. Then n=3 → 2 with `o_overflow` cleared.
- Mode 1, n=5 → 11 (sequence 2, 1, 3, 4, 7, 11), done tick at cycle 6.
- Boundary indices, each with done tick at cycle 2:
  - Mode 0: n=0 → 0, n=1 → 1.
  - Mode 1: n=0 → 2, n=1 → 1.
- Start pulses and `i_idx`/`i_mode` changes during OPERATE and DONE → ignored; the original result is delivered with exactly one done tick.
- Reset asserted mid-run (n=15, cycle 5) → next cycle `o_ready`=1, `o_final`=0, no done tick.
- `W`=32, `MAX_VAL`=2^32−1, mode 0:
  - n=47 → 2971215073, no overflow.
  - n=48 → 4294967295 with `o_overflow`=1.

Source files
------------

// File: rtl/fib_pkg.sv
// -----------------------------------------------------------------------------
// fib_pkg
// Shared types and constants for the Fibonacci/Lucas sequence engine.
//   t_fib_state : engine controller states
//   t_fib_mode  : sequence selector (Fibonacci or Lucas)
//   seed0/seed1 : first two terms of the selected sequence
// -----------------------------------------------------------------------------
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPERATE = 2'd1,
    DONE    = 2'd2
  } t_fib_state;

  typedef enum logic {
    FIB   = 1'b0,
    LUCAS = 1'b1
  } t_fib_mode;

  localparam int unsigned FIB_SEED0   = 0;
  localparam int unsigned FIB_SEED1   = 1;
  localparam int unsigned LUCAS_SEED0 = 2;
  localparam int unsigned LUCAS_SEED1 = 1;

  // Term 0 of the selected sequence.
  function automatic int unsigned seed0(input t_fib_mode mode);
    return (mode == LUCAS) ? LUCAS_SEED0 : FIB_SEED0;
  endfunction

  // Term 1 of the selected sequence.
  function automatic int unsigned seed1(input t_fib_mode mode);
    return (mode == LUCAS) ? LUCAS_SEED1 : FIB_SEED1;
  endfunction

endpackage

// File: rtl/fib_seq_engine_if.sv
// -----------------------------------------------------------------------------
// fib_seq_engine_if
// Request/response bundle between the input front end (master) and the
// sequence engine (slave).
//   i_start     : start request, honoured only while o_ready is high
//   i_mode      : 0 = Fibonacci, 1 = Lucas
//   i_idx       : sequence index n
//   o_ready     : engine idle, a start will be accepted
//   o_done_tick : one-cycle completion pulse
//   o_final     : result, held until the next completion
//   o_overflow  : result was clipped to the saturation ceiling
// -----------------------------------------------------------------------------
interface fib_seq_engine_if #(
  parameter int W     = 16,
  parameter int IDX_W = 6
);

  logic             i_start;
  logic             i_mode;
  logic [IDX_W-1:0] i_idx;
  logic             o_ready;
  logic             o_done_tick;
  logic [W-1:0]     o_final;
  logic             o_overflow;

  modport master (
    output i_start, i_mode, i_idx,
    input  o_ready, o_done_tick, o_final, o_overflow
  );

  modport slave (
    input  i_start, i_mode, i_idx,
    output o_ready, o_done_tick, o_final, o_overflow
  );

endinterface

// File: rtl/fib_sat_add.sv
// -----------------------------------------------------------------------------
// fib_sat_add
// Combinational adder for two sequence terms with a ceiling detector.
//   a, b : current terms (W bits)
//   sum  : low W bits of a + b
//   sat  : a + b (computed in W+1 bits, so it never wraps) exceeds MAX_VAL
// -----------------------------------------------------------------------------
module fib_sat_add #(
  parameter int              W       = 16,
  parameter longint unsigned MAX_VAL = 9999
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         sat
);

  localparam logic [63:0] MAX64 = MAX_VAL;
  localparam logic [W:0]  LIMIT = MAX64[W:0];

  logic [W:0] full_sum;

  // The carry bit is kept so a sum past 2^W-1 still compares as large.
  assign full_sum = {1'b0, a} + {1'b0, b};
  assign sum      = full_sum[W-1:0];
  assign sat      = (full_sum > LIMIT);

endmodule

// File: rtl/fib_seq_engine.sv
// -----------------------------------------------------------------------------
// fib_seq_engine
// Iterative Fibonacci/Lucas term generator with start/ready/done handshake.
// Each OPERATE cycle advances the pair (a, b) by one term and counts n down;
// the walk stops when n reaches 0 or 1, or as soon as a required term would
// exceed MAX_VAL, in which case the result is clipped and o_overflow is set.
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : fib_seq_engine_if slave (start/mode/idx in, ready/done/result out)
// -----------------------------------------------------------------------------
module fib_seq_engine
  import fib_pkg::*;
#(
  parameter int              W       = 16,
  parameter int              IDX_W   = 6,
  parameter longint unsigned MAX_VAL = 9999
) (
  input  logic             i_clk,
  input  logic             i_rst,
  fib_seq_engine_if.slave  bus
);

  // Reject parameter sets the datapath cannot represent.
  if (W < 2 || W > 63) begin : g_bad_width
    $error("fib_seq_engine: W must be in 2..63");
  end
  if (MAX_VAL < 64'd2 || MAX_VAL > ((64'd1 << W) - 64'd1)) begin : g_bad_max
    $error("fib_seq_engine: MAX_VAL must be in 2..2^W-1");
  end

  localparam logic [63:0]      MAX64   = MAX_VAL;
  localparam logic [W-1:0]     MAX_W   = MAX64[W-1:0];
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  t_fib_state       state_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [IDX_W-1:0] n_q;
  logic [W-1:0]     result_q;
  logic             overflow_q;
  logic             ready_q;
  logic             done_q;

  logic [W-1:0]     sum;
  logic             sat;
  t_fib_mode        start_mode;

  assign start_mode = t_fib_mode'(bus.i_mode);

  fib_sat_add #(
    .W       (W),
    .MAX_VAL (MAX_VAL)
  ) u_add (
    .a   (a_q),
    .b   (b_q),
    .sum (sum),
    .sat (sat)
  );

  // NOTE: every register here uses non-blocking assignment so all state moves
  // together on the edge; a blocking write would leak into later reads of the
  // same cycle and break the a/b shift.
  always_ff @(posedge i_clk) begin
    // NOTE: reset is synchronous and clears the datapath as well as the
    // controller, so an aborted run leaves no stale result on o_final.
    if (i_rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      n_q        <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.i_start) begin
            a_q        <= W'(seed0(start_mode));
            b_q        <= W'(seed1(start_mode));
            n_q        <= bus.i_idx;
            overflow_q <= 1'b0;
            ready_q    <= 1'b0;
            state_q    <= OPERATE;
          end
        end

        OPERATE: begin
          if (n_q == '0) begin
            result_q <= a_q;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else if (n_q == IDX_ONE) begin
            result_q <= b_q;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else if (sat) begin
            // Only reached when term n is still needed, so a clip here
            // always reflects a genuinely out-of-range result.
            result_q   <= MAX_W;
            overflow_q <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else begin
            a_q <= b_q;
            b_q <= sum;
            n_q <= n_q - IDX_ONE;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end

        // NOTE: the unused encoding recovers to IDLE instead of locking up.
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready     = ready_q;
  assign bus.o_done_tick = done_q;
  assign bus.o_final     = result_q;
  assign bus.o_overflow  = overflow_q;

endmodule
